// File: rtl/config_loader.sv
// config_loader: packet-driven configuration sequencer feeding the neuron core's config memories.
// Optional header parity check is enabled by defining CFG_LOADER_PARITY_EN.
module config_loader #(
    parameter int DSIZE                   = 16,
    parameter int NURN_CNT_BIT_WIDTH      = 8,
    parameter int AXON_CNT_BIT_WIDTH      = 8,
    parameter int CONFIG_PARAMETER_NUMBER = 9
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [DSIZE*2-1:0]                 pkt_data_i,
    input  logic                               pkt_valid_i,
    output logic                               pkt_ready_o,
    output logic [DSIZE*4-1:0]                 cfg_data_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]      cfg_addr_o,
    output logic [CONFIG_PARAMETER_NUMBER-1:0] cfg_we_o,
    output logic                               cfg_ce_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]      Number_Neuron_o,
    output logic [AXON_CNT_BIT_WIDTH-1:0]      Number_Axon_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o
);
    localparam int W  = DSIZE * 2;
    localparam int NW = NURN_CNT_BIT_WIDTH;
    localparam int AW = AXON_CNT_BIT_WIDTH;
    localparam int CW = CONFIG_PARAMETER_NUMBER;
    localparam logic [CW-1:0] WE_ONE = CW'(1);

    typedef enum logic [2:0] {IDLE, LO, HI, WRITE, DROP} state_e;

    state_e           state_q, state_d;
    logic [3:0]       tgt_q, tgt_d;
    logic [NW-1:0]    base_q, base_d, addr_q, addr_d, nn_q, nn_d;
    logic [AW-1:0]    na_q, na_d;
    logic [7:0]       n_q, n_d, idx_q, idx_d, drop_q, drop_d;
    logic [W-1:0]     lo_q, lo_d;
    logic [2*W-1:0]   data_q, data_d;
    logic             err_q, err_d;
    logic             acc, two_word, hdr_bad, fin;

    assign acc      = pkt_valid_i && pkt_ready_o;
    assign two_word = tgt_q != 4'd2 && tgt_q != 4'd7;
    assign fin      = acc && (state_q == HI || (state_q == LO && !two_word));
`ifdef CFG_LOADER_PARITY_EN
    assign hdr_bad  = pkt_data_i[31] | (^pkt_data_i);
`else
    assign hdr_bad  = pkt_data_i[31];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            nn_q    <= '0;
            na_q    <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            drop_q  <= '0;
            lo_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            nn_q    <= nn_d;
            na_q    <= na_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc) state_d = hdr_bad ? DROP : LO;
            LO:      if (acc) state_d = two_word ? HI : WRITE;
            HI:      if (acc) state_d = WRITE;
            WRITE:   state_d = (idx_q == n_q || tgt_q == 4'd7) ? IDLE : LO;
            DROP:    if (acc && drop_q == 8'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output registers (data/addr/counts) only change when an entry completes,
    // so cfg_data_o/cfg_addr_o hold between writes while the next entry assembles.
    always_comb begin
        tgt_d  = tgt_q;
        base_d = base_q;
        addr_d = addr_q;
        nn_d   = nn_q;
        na_d   = na_q;
        n_d    = n_q;
        idx_d  = idx_q;
        drop_d = drop_q;
        lo_d   = lo_q;
        data_d = data_q;
        err_d  = 1'b0;
        if (state_q == IDLE && acc) begin
            tgt_d  = pkt_data_i[31:28];
            base_d = NW'(pkt_data_i[27:20]);
            n_d    = pkt_data_i[19:12];
            drop_d = pkt_data_i[19:12];
            idx_d  = 8'd0;
            err_d  = hdr_bad;
        end
        if (state_q == LO && acc)
            lo_d = pkt_data_i;
        if (fin && tgt_q == 4'd7) begin
            nn_d = NW'(pkt_data_i[15:8]);
            na_d = AW'(pkt_data_i[7:0]);
        end else if (fin) begin
            data_d = state_q == HI ? {pkt_data_i, lo_q} : {{W{1'b0}}, pkt_data_i};
            addr_d = base_q + NW'(idx_q);
        end
        if (state_q == WRITE && state_d == LO)
            idx_d = idx_q + 8'd1;
        if (state_q == DROP && acc)
            drop_d = drop_q - 8'd1;
    end

    always_comb begin
        pkt_ready_o     = state_q != WRITE;
        busy_o          = state_q != IDLE;
        cfg_we_o        = (state_q == WRITE && tgt_q < 4'd7) ? WE_ONE << tgt_q : '0;
        cfg_ce_o        = |cfg_we_o;
        done_o          = state_q == WRITE && (idx_q == n_q || tgt_q == 4'd7);
        err_o           = err_q;
        cfg_data_o      = data_q;
        cfg_addr_o      = addr_q;
        Number_Neuron_o = nn_q;
        Number_Axon_o   = na_q;
    end
endmodule

// File: doc/config_loader.md
# config_loader

Packet-driven configuration sequencer for the neuron core's configuration memories.
- Accepts 32-bit configuration words from the router-side packet port with a valid/ready handshake.
- Decodes a header word and assembles one- or two-word entries.
- Issues one write pulse per entry to the downstream configuration memory block on its config data/write-enable/address inputs.
- Also holds the core's neuron-count and axon-count registers.

## Interface
Parameters:
- DSIZE, 16, datapath half-width; packet word width is DSIZE*2
- NURN_CNT_BIT_WIDTH, 8, neuron address width
- AXON_CNT_BIT_WIDTH, 8, axon count width
- CONFIG_PARAMETER_NUMBER, 9, width of one-hot write-enable bus

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- pkt_data_i  in  DSIZE*2  packet word
- pkt_valid_i  in  1  word valid
- pkt_ready_o  out  1  word accepted when valid&ready
- cfg_data_o  out  DSIZE*4  assembled entry, low word in [31:0]
- cfg_addr_o  out  NURN_CNT_BIT_WIDTH  neuron address of the entry
- cfg_we_o  out  CONFIG_PARAMETER_NUMBER  one-hot memory write enable
- cfg_ce_o  out  1  memory clock-enable, equal to OR of cfg_we_o
- Number_Neuron_o  out  NURN_CNT_BIT_WIDTH  configured neuron count
- Number_Axon_o  out  AXON_CNT_BIT_WIDTH  configured axon count
- busy_o  out  1  high whenever state is not IDLE
- done_o  out  1  one-cycle pulse with the last write of a packet
- err_o  out  1  one-cycle pulse when a packet is dropped

## Operation
Header word fields:
- [31:28] target (T)
- [27:20] base address (B)
- [19:12] entry count minus one (N), giving 1..256 entries
- [11:1] reserved
- [0] parity

Targets:
- 0 = mem A, 2 words
- 1 = mem B, 2 words
- 2 = AER, 1 word
- 3..6 = axon mode 1..4, 2 words each
- 7 = counts, 1 word: Number_Neuron_o <= word[15:8], Number_Axon_o <= word[7:0]; no cfg_we_o
- 8..15 are invalid

State machine:
- IDLE: accept header. Valid target: latch T, B, N; entry index i=0; go to LO. Invalid target: pulse err_o, go to DROP with N+1 words remaining.
- LO: accept a word into data[31:0] and clear data[63:32]. 2-word target goes to HI; 1-word target goes to WRITE.
- HI: accept a word into data[63:32], go to WRITE.
- WRITE: pkt_ready_o=0.
  - Targets 0..6: cfg_we_o[T]=1, cfg_addr_o=(B+i) mod 256.
  - Target 7: update the count registers.
  - If i==N: pulse done_o, go to IDLE. Otherwise i<=i+1, go to LO.
- DROP: accept and discard words; return to IDLE after the last one.

Rules:
- cfg_we_o bits 7..CONFIG_PARAMETER_NUMBER-1 are always 0.
- Address wraps mod 2^NURN_CNT_BIT_WIDTH: B=0xFF, N=1 writes 0xFF then 0x00.
- Target 7 ignores N after the first entry and always ends the packet after one write.

## Timing
- Reset (any state, mid-packet included):
  - state IDLE; partial entry discarded
  - all outputs 0, except pkt_ready_o=1 in the cycle after reset deasserts
  - Number_Neuron_o and Number_Axon_o cleared to 0
- pkt_ready_o=1 in IDLE, LO, HI and DROP; 0 in WRITE.
- A word transfers only on a cycle with valid&ready; bubbles in pkt_valid_i stall the FSM with no side effects.
- Write latency:
  - cfg_we_o asserts in the cycle after the final word of an entry is accepted, for exactly one cycle.
  - cfg_data_o and cfg_addr_o hold valid that cycle and keep their value until the next write.
- Throughput: 3 cycles per 2-word entry, 2 cycles per 1-word entry.
- IDLE follows WRITE directly, so a new header can be accepted the cycle after done_o.
- done_o and err_o never assert in the same cycle.

## Configuration
- CFG_LOADER_PARITY_EN defined:
  - Header bit 0 must make the 32-bit header even parity.
  - On mismatch: pulse err_o, go to DROP for N+1 words, perform no writes.
- Undefined: bit 0 is ignored; only an invalid target causes a drop.

## Test plan
- Header T=0, B=0x10, N=1, then words 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> cfg_we_o=9'h001 on two cycles; addresses 0x10 then 0x11; data 0x2222222211111111 then 0x4444444433333333; done_o with the second write.
- Header T=2, B=0xFF, N=1, then two AER words -> cfg_we_o=9'h004; addresses 0xFF then 0x00; upper 32 data bits 0.
- Header T=7, data 0x00000A05 -> Number_Neuron_o=0x0A, Number_Axon_o=0x05; cfg_we_o stays 0.
- Header T=9, N=2, then 3 words -> err_o one pulse; all 3 words consumed; no cfg_we_o; next valid packet writes normally.
- Random pkt_valid_i bubbles during a T=1 packet -> identical writes to the no-bubble run; pkt_ready_o low only in WRITE.
- rst_i asserted after the LO word of a T=3 packet -> no write; state IDLE; counts 0. With CFG_LOADER_PARITY_EN, a header with odd parity -> err_o and a drop.
